// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, the single arithmetic cell of the serial subtractor.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             fa_s, fa_co;
    logic [WIDTH:0]   r_shift;

    fa_cell u_fa (
        .x  (a_sr_q[0]),
        .y  (~b_sr_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bit enters at the MSB; the slice keeps WIDTH=1 legal.
    assign r_shift = {fa_s, r_sr_q};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        r_sr_d   = r_sr_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = r_shift[WIDTH:1];
                c_d    = fa_co;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    diff_d   = r_shift[WIDTH:1];
                    borrow_d = ~fa_co;
`ifdef SERIAL_SUB_OVF_EN
                    // c_q is the carry into the MSB stage, fa_co the carry out of it.
                    ovf_d    = c_q ^ fa_co;
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            r_sr_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            r_sr_q   <= r_sr_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, diff8;
    logic [0:0] a1, b1, diff1;
    logic       busy8, done8, borrow8;
    logic       busy1, done1, borrow1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf1;
`endif

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf8),
`endif
        .borrow (borrow8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf1),
`endif
        .borrow (borrow1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the WIDTH=8 unit is idle; returns one cycle after done.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        a8 = av;
        b8 = bv;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("lat8", n, 9);
        chk("diff8", diff8, ed);
        chk("borrow8", borrow8, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf8", ovf8, eo);
`endif
        @(negedge clk);
        chk("pulse8", done8, 1'b0);
    endtask

    task automatic run1(input logic av, input logic bv,
                        input logic ed, input logic eb, input logic eo);
        int n;
        a1 = av;
        b1 = bv;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("lat1", n, 2);
        chk("diff1", diff1, ed);
        chk("borrow1", borrow1, eb);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf1", ovf1, eo);
`endif
        @(negedge clk);
        chk("pulse1", done1, 1'b0);
    endtask

    initial begin
        logic [19:0] seen;
        logic        saw_done;
        logic [7:0]  ra, rb, rd;
        logic        sa, sb;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_diff", diff8, 8'h00);
        chk("rst_borrow", borrow8, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf8, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run8(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        run1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // start held high: accepts every 10 cycles, operand changes mid-RUN ignored
        a8 = 8'h10;
        b8 = 8'h01;
        start8 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            seen[i-1] = busy8;
            if (i == 2) begin
                a8 = 8'hFF;
                b8 = 8'h00;
            end
            if (i == 9) begin
                chk("hold_done1", done8, 1'b1);
                chk("hold_diff1", diff8, 8'h0F);
            end
            if (i == 19) begin
                chk("hold_done2", done8, 1'b1);
                chk("hold_diff2", diff8, 8'hFF);
            end
            if (i == 20) start8 = 1'b0;
        end
        chk("busy_pattern", seen, 20'h7FDFF);
        @(negedge clk);

        // leave nonzero outputs, then reset during RUN cycle 4
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        a8 = 8'h20;
        b8 = 8'h01;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy8, 1'b0);
        chk("abort_done", done8, 1'b0);
        chk("abort_diff", diff8, 8'h00);
        chk("abort_borrow", borrow8, 1'b0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done = saw_done | done8;
        end
        chk("abort_nodone", saw_done, 1'b0);
        run8(8'h20, 8'h01, 8'h1F, 1'b0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run8(ra, rb, rd, (ra < rb), (ra[7] != rb[7]) && (rd[7] != ra[7]));
        end

        for (int k = 0; k < 1000; k++) begin
            sa = 1'($urandom);
            sb = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run1(sa, sb, sa ^ sb, (!sa && sb), (sa != sb) && ((sa ^ sb) != sa));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It is the subtract-direction counterpart of our combinational full-adder work: it trades WIDTH cycles of latency for one adder cell. It sits behind a simple start/done handshake, so a controller or testbench can issue operand pairs back-to-back.

## Interface
- `WIDTH`, default 8, operand and result width in bits (≥1).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; captured on the accepted start edge.
- `b`  in  WIDTH  subtrahend; captured on the accepted start edge.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; result valid.
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH; holds until the next accepted start completes.
- `borrow`  out  1  unsigned borrow (a < b); holds with `diff`.
- `ovf`  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN when `start` = 1:
  - load shift registers `a_sr` ← `a` and `b_sr` ← `b`;
  - set carry register `c` ← 1, so the subtraction computes `a + ~b + 1`;
  - clear bit counter to 0.
- RUN, each cycle:
  - `s = a_sr[0] ^ ~b_sr[0] ^ c`; `c` ← majority(`a_sr[0]`, `~b_sr[0]`, `c`);
  - `s` shifts into the MSB of result shift register `r_sr`; `a_sr` and `b_sr` shift right;
  - counter increments.
- RUN → DONE after exactly WIDTH RUN cycles (counter == WIDTH-1 on the last).
- DONE lasts one cycle:
  - `done` = 1;
  - `diff` ← `r_sr` (fully shifted) and `borrow` ← `~c` are registered on entry to DONE;
  - DONE → IDLE unconditionally.
- `start` in RUN or DONE is ignored; no queueing. The requester must re-assert in IDLE.
- Operands changing after the capture edge have no effect.
- Counter width is $clog2(WIDTH+1). WIDTH=1 yields exactly one RUN cycle.

## Timing
- Start accepted at edge k.
- RUN occupies cycles k+1 .. k+WIDTH.
- `done` is high in cycle k+WIDTH+1. Latency is WIDTH+1 clocks from the accepting edge to `done` high.
- Earliest next accept is edge k+WIDTH+2, in IDLE. Throughput is one result per WIDTH+2 cycles.
- `diff`, `borrow` and `ovf` change only on the edge entering DONE.
- `busy` is registered and high from cycle k+1 through the DONE cycle.
- Reset values: state IDLE, `busy` 0, `done` 0, `diff` 0, `borrow` 0, `ovf` 0, internal shift registers/counter/carry 0.
- Reset asserted mid-RUN or in DONE:
  - the operation aborts;
  - no `done` pulse is issued;
  - outputs return to their reset values on that edge.
- Reset has priority over `start` when both are high on the same edge.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - port `ovf` exists and is registered in DONE as (carry into the MSB stage) XOR (carry out of the MSB stage);
  - the carry into the MSB stage is held in a 1-bit register captured on the last RUN cycle.
- `SERIAL_SUB_OVF_EN` undefined:
  - the `ovf` port and its register are absent;
  - all other behaviour is identical.

## Structure
- Shared package `serial_sub_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant.
- One sub-module, `fa_cell`: combinational 1-bit full adder (`x`, `y`, `ci` → `s`, `co`), instantiated once with `y = ~b_sr[0]`.
- FSM, counter and shift registers live in the top.

## Test plan
- WIDTH=8, a=0x05, b=0x03, start 1 cycle → `done` at start-edge+9; `diff` 0x02, `borrow` 0, `ovf` 0.
- a=0x03, b=0x05 → `diff` 0xFE, `borrow` 1, `ovf` 0. Boundary pair a=0x00, b=0x00 → `diff` 0x00, `borrow` 0.
- a=0x80, b=0x01 → `diff` 0x7F, `borrow` 0, `ovf` 1 (macro on). With the macro off, the `ovf` port is absent and `diff`/`borrow` are the same.
- Hold `start` high continuously → accepts every 10 cycles only; `busy` pattern is 9 high, 1 low; `a`/`b` changes mid-RUN do not affect the result.
- Assert `rst` for 1 cycle at RUN cycle 4 → no `done`; all outputs 0; a new start afterwards produces a correct result.
- 1000 random operand pairs at WIDTH=8 and WIDTH=1, each with random `a`/`b` and random start gaps → `diff` == (a-b) mod 2^WIDTH and `borrow` == (a<b) on every `done`.
